// File: rtl/nn_serial_pkg.sv
// Shared definitions for the serial clock/data/push-buffer link
// (used by both the input loader and the output transmitter).
package nn_serial_pkg;

  // Frame state machine encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PUSH  = 2'd2
  } serial_state_t;

  // Link defaults shared between the transmit and receive ends.
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int SERIAL_CLK_DIV     = 4;

  // Width of a counter that must hold 0..count-1; never narrower than 1 bit.
  function automatic int cnt_width(input int count);
    return (count <= 1) ? 1 : $clog2(count);
  endfunction

  // Cycles a frame keeps the link busy: n_bits bit slots plus one push slot,
  // each slot being a full serial_clock period of 2*clk_div cycles.
  function automatic int frame_cycles(input int clk_div, input int n_bits);
    return 2 * clk_div * (n_bits + 1);
  endfunction

endpackage

// File: rtl/serial_phase_gen.sv
// Serial clock phase generator: divides the system clock into low and high
// half-periods of CLK_DIV cycles each and flags the last cycle of each.
module serial_phase_gen
  import nn_serial_pkg::*;
#(
  parameter int CLK_DIV = SERIAL_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CNT_W = cnt_width(CLK_DIV);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic             phase_high;
  logic             half_end;

  assign half_end  = (div_cnt == DIV_LAST);
  // rise_tick: the coming edge ends a low phase; fall_tick: it ends a high phase.
  assign rise_tick = enable && !phase_high && half_end;
  assign fall_tick = enable &&  phase_high && half_end;

  // Half-period counter; held at the start of a low phase while disabled so
  // every frame begins with a full low half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      phase_high <= 1'b0;
    end else if (!enable) begin
      div_cnt    <= '0;
      phase_high <= 1'b0;
    end else if (half_end) begin
      div_cnt    <= '0;
      phase_high <= ~phase_high;
    end else begin
      div_cnt    <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/output_shift_register.sv
// Parallel-in, serial-out transmitter for the result vector: captures all
// words in one handshake, shifts them out word 0 first / MSB first on a
// serial clock/data pair, then strobes push_buffer so the receiver latches.
module output_shift_register
  import nn_serial_pkg::*;
#(
  parameter int NUM_OUTPUTS = 10,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int CLK_DIV     = SERIAL_CLK_DIV
) (
  input  logic                              CLOCK_50,
  input  logic                              resetn,
  input  logic [NUM_OUTPUTS*DATA_WIDTH-1:0] data_in,
  input  logic                              load_valid,
  output logic                              load_ready,
  input  logic                              abort,
  output logic                              serial_clock,
  output logic                              serial_data,
  output logic                              push_buffer,
  output logic                              busy,
  output logic                              done
);

  localparam int N     = NUM_OUTPUTS * DATA_WIDTH;
  localparam int BIT_W = cnt_width(N);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(N - 1);

  serial_state_t    state;
  logic [N-1:0]     shift_reg;
  logic [N-1:0]     shift_next;
  logic [N-1:0]     stream_vec;
  logic [BIT_W-1:0] bit_cnt;
  logic             phase_enable;
  logic             rise_tick;
  logic             fall_tick;

  // Reorder the words so the transmit order is simply MSB-first of
  // stream_vec: word 0 lands in the top slot, the last word in the bottom.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_word
      assign stream_vec[(NUM_OUTPUTS-1-gi)*DATA_WIDTH +: DATA_WIDTH] =
        data_in[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Next bit to send always sits at the top after a left shift.
  assign shift_next = shift_reg << 1;

  // The divider runs for the whole frame (SHIFT and PUSH) and is cleared by
  // an abort so the next frame starts from a clean low phase.
  assign phase_enable = (state != IDLE) && !abort;

  serial_phase_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_phase (
    .clk       (CLOCK_50),
    .rst_n     (resetn),
    .enable    (phase_enable),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // Frame FSM with registered outputs: capture, shift bits on high-phase
  // ends, hold push_buffer for one serial period, then report done.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      serial_clock <= 1'b0;
      serial_data  <= 1'b0;
      push_buffer  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      load_ready   <= 1'b1;
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        // Cancel: drop the frame silently, no push and no done.
        state        <= IDLE;
        shift_reg    <= '0;
        bit_cnt      <= '0;
        serial_clock <= 1'b0;
        serial_data  <= 1'b0;
        push_buffer  <= 1'b0;
        busy         <= 1'b0;
        load_ready   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            // abort wins over a simultaneous load request.
            if (load_valid && !abort) begin
              state        <= SHIFT;
              shift_reg    <= stream_vec;
              bit_cnt      <= '0;
              serial_clock <= 1'b0;
              serial_data  <= stream_vec[N-1];
              busy         <= 1'b1;
              load_ready   <= 1'b0;
            end
          end
          SHIFT: begin
            if (rise_tick) begin
              serial_clock <= 1'b1;
            end else if (fall_tick) begin
              // Data only moves on a falling serial_clock, giving a full
              // half-period of setup and hold around each rising edge.
              serial_clock <= 1'b0;
              if (bit_cnt != LAST_BIT) begin
                shift_reg   <= shift_next;
                serial_data <= shift_next[N-1];
                bit_cnt     <= bit_cnt + 1'b1;
              end else begin
                state       <= PUSH;
                serial_data <= 1'b0;
                push_buffer <= 1'b1;
              end
            end
          end
          PUSH: begin
            // push_buffer spans one full serial period, ending on a fall_tick.
            if (fall_tick) begin
              state       <= IDLE;
              push_buffer <= 1'b0;
              busy        <= 1'b0;
              load_ready  <= 1'b1;
              done        <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_output_shift_register.sv
// Bench for output_shift_register: a small instance (2 words x 4 bits,
// CLK_DIV=2) checked cycle by cycle against a frame-timing model, plus a
// default-size instance checked through a serial receiver.
module tb_output_shift_register;

  localparam int S_NO    = 2;
  localparam int S_DW    = 4;
  localparam int S_CD    = 2;
  localparam int S_N     = S_NO * S_DW;
  localparam int S_FRAME = 2 * S_CD * (S_N + 1);   // 36
  localparam int D_NO    = 10;
  localparam int D_DW    = 16;
  localparam int D_CD    = 4;
  localparam int D_N     = D_NO * D_DW;            // 160

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn = 1'b0;

  // Small instance signals
  logic [S_N-1:0] din_s = '0;
  logic lv_s = 1'b0;
  logic ab_s = 1'b0;
  logic lr_s, sclk_s, sdat_s, push_s, busy_s, done_s;

  // Default instance signals
  logic [D_N-1:0] din_d = '0;
  logic lv_d = 1'b0;
  logic ab_d = 1'b0;
  logic lr_d, sclk_d, sdat_d, push_d, busy_d, done_d;

  output_shift_register #(
    .NUM_OUTPUTS (S_NO),
    .DATA_WIDTH  (S_DW),
    .CLK_DIV     (S_CD)
  ) dut_s (
    .CLOCK_50     (clk),
    .resetn       (resetn),
    .data_in      (din_s),
    .load_valid   (lv_s),
    .load_ready   (lr_s),
    .abort        (ab_s),
    .serial_clock (sclk_s),
    .serial_data  (sdat_s),
    .push_buffer  (push_s),
    .busy         (busy_s),
    .done         (done_s)
  );

  output_shift_register #(
    .NUM_OUTPUTS (D_NO),
    .DATA_WIDTH  (D_DW),
    .CLK_DIV     (D_CD)
  ) dut_d (
    .CLOCK_50     (clk),
    .resetn       (resetn),
    .data_in      (din_d),
    .load_valid   (lv_d),
    .load_ready   (lr_d),
    .abort        (ab_d),
    .serial_clock (sclk_d),
    .serial_data  (sdat_d),
    .push_buffer  (push_d),
    .busy         (busy_d),
    .done         (done_d)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // ---------------- frame-level model of the small instance ----------------
  // m_off counts cycles since acceptance; outputs follow from where that
  // offset falls in the frame (bit slot, low/high half, push slot).
  logic           m_active;
  logic           m_done;
  int             m_off;
  logic [S_N-1:0] m_data;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_off    <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_active && ab_s) begin
        m_active <= 1'b0;
      end else if (!m_active) begin
        if (lv_s && !ab_s) begin
          m_active <= 1'b1;
          m_off    <= 0;
          m_data   <= din_s;
        end
      end else if (m_off == S_FRAME - 1) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end else begin
        m_off <= m_off + 1;
      end
    end
  end

  // Expected {load_ready, serial_clock, serial_data, push_buffer, busy, done}
  function automatic logic [5:0] mdl_exp(input logic act, input logic dn,
                                         input int off, input logic [S_N-1:0] d);
    int   j;
    logic hi;
    logic bitv;
    if (!act) return {1'b1, 4'b0000, dn};
    if (off < 2 * S_CD * S_N) begin
      j    = off / (2 * S_CD);
      hi   = (off % (2 * S_CD)) >= S_CD;
      bitv = d[(j / S_DW) * S_DW + S_DW - 1 - (j % S_DW)];
      return {1'b0, hi, bitv, 1'b0, 1'b1, 1'b0};
    end
    return 6'b000110;
  endfunction

  logic prev_sclk = 1'b0;
  logic prev_sdat = 1'b0;

  // Per-cycle comparison against the model plus serial_data stability.
  always @(negedge clk) begin
    if (resetn) begin
      chk("cycle", 64'({lr_s, sclk_s, sdat_s, push_s, busy_s, done_s}),
          64'(mdl_exp(m_active, m_done, m_off, m_data)));
      if (prev_sclk && sclk_s)
        chk("data_stable_while_high", 64'(sdat_s), 64'(prev_sdat));
    end
    prev_sclk <= resetn & sclk_s;
    prev_sdat <= sdat_s;
  end

  // ---------------- receiver for the default instance ----------------
  logic [D_N-1:0] rx_sh;
  logic [D_N-1:0] rx_latched;
  int             rx_cnt = 0;

  always @(posedge sclk_d) begin
    rx_sh  <= {rx_sh[D_N-2:0], sdat_d};
    rx_cnt <= rx_cnt + 1;
  end

  always @(posedge push_d) rx_latched <= rx_sh;

  // ---------------- small-instance observation helpers ----------------
  logic [15:0] rise_bits;
  int n_rise, first_rise, n_busy, n_push, done_idx;
  logic ps;

  task automatic clear_s();
    rise_bits  = '0;
    n_rise     = 0;
    first_rise = -1;
    n_busy     = 0;
    n_push     = 0;
    done_idx   = -1;
    ps         = sclk_s;
  endtask

  task automatic sample_s(input int i);
    if (sclk_s && !ps) begin
      rise_bits = {rise_bits[14:0], sdat_s};
      n_rise++;
      if (first_rise < 0) first_rise = i;
    end
    ps = sclk_s;
    if (busy_s) n_busy++;
    if (push_s) n_push++;
    if (done_s) done_idx = i;
  endtask

  initial begin
    int   base;
    int   busy_cnt;
    logic got_done;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("reset_small", 64'({lr_s, sclk_s, sdat_s, push_s, busy_s, done_s}), 64'(6'b100000));
    chk("reset_default", 64'({lr_d, sclk_d, sdat_d, push_d, busy_d, done_d}), 64'(6'b100000));
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // ---- basic frame 8'hA5 ----
    clear_s();
    din_s = 8'hA5;
    lv_s  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      sample_s(i);
      if (i == 0) lv_s = 1'b0;
    end
    $display("frame A5: rises=%0d bits=%02h busy=%0d push=%0d done_at=%0d",
             n_rise, rise_bits[7:0], n_busy, n_push, done_idx);
    chk("a5_rise_count", 64'(n_rise), 64'(8));
    chk("a5_bits", 64'(rise_bits[7:0]), 64'(8'h5A));
    chk("a5_first_rise", 64'(first_rise), 64'(S_CD));
    chk("a5_busy_len", 64'(n_busy), 64'(36));
    chk("a5_push_len", 64'(n_push), 64'(4));
    chk("a5_done_idx", 64'(done_idx), 64'(36));

    // ---- ignored mid-frame load, then abort during bit 3 ----
    clear_s();
    din_s = 8'hC3;
    lv_s  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      sample_s(i);
      if (i == 0) lv_s = 1'b0;
      if (i == 5) begin lv_s = 1'b1; din_s = 8'h00; end
      if (i == 6) lv_s = 1'b0;
      if (i == 13) ab_s = 1'b1;
      if (i == 14) begin
        ab_s = 1'b0;
        chk("abort_idle", 64'({lr_s, sclk_s, sdat_s, push_s, busy_s, done_s}), 64'(6'b100000));
      end
    end
    $display("frame C3 aborted: rises=%0d bits=%01h push=%0d done_at=%0d",
             n_rise, rise_bits[2:0], n_push, done_idx);
    chk("abort_rise_count", 64'(n_rise), 64'(3));
    chk("abort_bits", 64'(rise_bits[2:0]), 64'(3'b001));
    chk("abort_no_push", 64'(n_push), 64'(0));
    chk("abort_no_done", 64'(done_idx), 64'(-1));

    // ---- back-to-back frames with load_valid held ----
    clear_s();
    din_s = 8'h3C;
    lv_s  = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      sample_s(i);
      if (i == 0) din_s = 8'h96;
      if (i == 36) chk("b2b_done_cycle", 64'({done_s, lr_s, busy_s}), 64'(3'b110));
      if (i == 37) begin
        chk("b2b_restart", 64'(busy_s), 64'(1));
        lv_s = 1'b0;
      end
    end
    $display("frames 3C,96 back-to-back: rises=%0d bits=%04h done_at=%0d",
             n_rise, rise_bits, done_idx);
    chk("b2b_rise_count", 64'(n_rise), 64'(16));
    chk("b2b_bits", 64'(rise_bits), 64'(16'hC369));
    chk("b2b_second_done", 64'(done_idx), 64'(73));

    // ---- default parameters, random vector ----
    for (int k = 0; k < 5; k++) din_d[k*32 +: 32] = $urandom;
    base = rx_cnt;
    lv_d = 1'b1;
    @(negedge clk);
    lv_d = 1'b0;
    busy_cnt = (busy_d === 1'b1) ? 1 : 0;
    got_done = 1'b0;
    for (int i = 0; i < 2000 && !got_done; i++) begin
      @(negedge clk);
      if (busy_d) busy_cnt++;
      if (done_d) got_done = 1'b1;
    end
    $display("default frame: bits=%0d busy=%0d done=%0d", rx_cnt - base, busy_cnt, got_done);
    chk("dflt_done_seen", 64'(got_done), 64'(1));
    chk("dflt_busy_len", 64'(busy_cnt), 64'(1288));
    chk("dflt_bit_count", 64'(rx_cnt - base), 64'(160));
    for (int k = 0; k < D_NO; k++)
      chk($sformatf("dflt_word%0d", k), 64'(rx_latched[D_N-1-k*D_DW -: D_DW]),
          64'(din_d[k*D_DW +: D_DW]));

    // ---- asynchronous reset mid-SHIFT, then idle ----
    din_s = 8'hFF;
    lv_s  = 1'b1;
    @(negedge clk);
    lv_s = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_reset_active", 64'({busy_s, sclk_s, sdat_s}), 64'(3'b111));
    #2 resetn = 1'b0;
    #1 chk("async_reset", 64'({lr_s, sclk_s, sdat_s, push_s, busy_s, done_s}), 64'(6'b100000));
    @(negedge clk);
    resetn = 1'b1;
    clear_s();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      sample_s(i);
    end
    $display("idle after reset: rises=%0d busy=%0d push=%0d done_at=%0d",
             n_rise, n_busy, n_push, done_idx);
    chk("idle_activity", 64'({n_rise[7:0], n_busy[7:0], n_push[7:0]}), 64'(0));
    chk("idle_no_done", 64'(done_idx), 64'(-1));
    chk("idle_outputs", 64'({lr_s, sclk_s, sdat_s, push_s, busy_s, done_s}), 64'(6'b100000));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
